// File: rtl/oq_rr_scheduler_pkg.sv
// rtl/oq_rr_scheduler_pkg.sv - shared output-queue scheduler defaults and state encoding
package oq_rr_scheduler_pkg;

    localparam int OQ_NUM_QUEUES = 5;
    localparam int OQ_DATA_WIDTH = 202;
    localparam int OQ_QID_WIDTH  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } oq_state_t;

endpackage

// File: rtl/oq_rr_scheduler_rr_pick.sv
// rtl/oq_rr_scheduler_rr_pick.sv - rotating-priority pick of the first eligible queue at or after rr_ptr
module oq_rr_scheduler_rr_pick
    import oq_rr_scheduler_pkg::*;
#(
    parameter int NUM_QUEUES = OQ_NUM_QUEUES,
    parameter int QID_WIDTH  = OQ_QID_WIDTH
) (
    input  logic [NUM_QUEUES-1:0] eligible,
    input  logic [QID_WIDTH-1:0]  rr_ptr,
    output logic                  found,
    output logic [QID_WIDTH-1:0]  idx
);

    // One extra bit so rr_ptr + offset cannot overflow before the modulo fold.
    logic [QID_WIDTH:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            cand = {1'b0, rr_ptr} + (QID_WIDTH+1)'(i);
            if (cand >= (QID_WIDTH+1)'(NUM_QUEUES)) begin
                cand = cand - (QID_WIDTH+1)'(NUM_QUEUES);
            end
            for (int k = 0; k < NUM_QUEUES; k++) begin
                if (!found && cand == (QID_WIDTH+1)'(k) && eligible[k]) begin
                    found = 1'b1;
                    idx   = QID_WIDTH'(k);
                end
            end
        end
    end

endmodule

// File: rtl/oq_rr_scheduler.sv
// rtl/oq_rr_scheduler.sv - round-robin packet scheduler from output queues to a single SRAM writer
module oq_rr_scheduler
    import oq_rr_scheduler_pkg::*;
#(
    parameter int NUM_QUEUES = OQ_NUM_QUEUES,
    parameter int DATA_WIDTH = OQ_DATA_WIDTH,
    parameter int QID_WIDTH  = OQ_QID_WIDTH
) (
    input  logic                             memclk,
    input  logic                             memreset,
    input  logic                             next_pkg_en,
    input  logic [NUM_QUEUES-1:0]            q_valid,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_data,
    input  logic [NUM_QUEUES-1:0]            q_last,
    input  logic [NUM_QUEUES-1:0]            space_ok,
    output logic [NUM_QUEUES-1:0]            q_ready,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid,
    output logic                             dout_last,
    input  logic                             dout_ready,
    output logic [QID_WIDTH-1:0]             queue_id,
    output logic                             busy,
    output logic [31:0]                      pkt_count
);

    oq_state_t            state, state_nxt;
    logic [QID_WIDTH-1:0] grant, grant_nxt;
    logic [QID_WIDTH-1:0] rr_ptr, ptr_nxt;
    logic [31:0]          count, count_nxt;
    logic [NUM_QUEUES-1:0] eligible;
    logic                 pick_found;
    logic [QID_WIDTH-1:0] pick_idx;

    assign eligible = q_valid & space_ok;

    oq_rr_scheduler_rr_pick #(
        .NUM_QUEUES (NUM_QUEUES),
        .QID_WIDTH  (QID_WIDTH)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Zero-latency mux of the granted queue; reset forces the handshake quiet.
    always_comb begin
        q_ready    = '0;
        dout       = '0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        if (!memreset && state == ST_XFER) begin
            for (int k = 0; k < NUM_QUEUES; k++) begin
                if (grant == QID_WIDTH'(k)) begin
                    dout       = q_data[k*DATA_WIDTH +: DATA_WIDTH];
                    dout_valid = q_valid[k];
                    dout_last  = q_last[k];
                    q_ready[k] = dout_ready;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = rr_ptr;
        count_nxt = count;
        case (state)
            ST_IDLE: begin
                if (next_pkg_en && pick_found) begin
                    state_nxt = ST_XFER;
                    grant_nxt = pick_idx;
                end
            end
            ST_XFER: begin
                if (dout_valid && dout_ready && dout_last) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = (grant == QID_WIDTH'(NUM_QUEUES-1)) ? '0 : grant + QID_WIDTH'(1);
                    count_nxt = count + 32'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge memclk) begin
        if (memreset) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= ptr_nxt;
            count  <= count_nxt;
        end
    end

    assign queue_id  = grant;
    assign busy      = (state == ST_XFER) && !memreset;
    assign pkt_count = count;

endmodule

// File: doc/oq_rr_scheduler.md
OQ_RR_SCHEDULER -- requirements
Module: oq_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 5: number of output-queue requesters.
REQ-002 SHALL have parameter DATA_WIDTH, default 202: width of one queued word, matching the Axi2Fifo dout word.
REQ-003 SHALL have parameter QID_WIDTH, default 3: width of queue_id.
REQ-004 SHALL have port memclk, input, 1: the single clock; one clock, all logic on the rising edge.
REQ-005 SHALL have port memreset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port next_pkg_en, input, 1: permits new packet grants.
REQ-007 SHALL have port q_valid, input, NUM_QUEUES: per-queue word valid.
REQ-008 SHALL have port q_data, input, NUM_QUEUES*DATA_WIDTH: per-queue word; queue k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port q_last, input, NUM_QUEUES: per-queue end-of-packet flag.
REQ-010 SHALL have port space_ok, input, NUM_QUEUES: the SRAM region of queue k can accept one maximum-size packet.
REQ-011 SHALL have port q_ready, output, NUM_QUEUES: per-queue word pop.
REQ-012 SHALL have port dout, output, DATA_WIDTH: granted word.
REQ-013 SHALL have port dout_valid, output, 1: dout is valid.
REQ-014 SHALL have port dout_last, output, 1: dout is the last word of its packet.
REQ-015 SHALL have port dout_ready, input, 1: downstream (SRAM writer) accepts dout.
REQ-016 SHALL have port queue_id, output, QID_WIDTH: binary index of the granted queue.
REQ-017 SHALL have port busy, output, 1: a packet grant is active.
REQ-018 SHALL have port pkt_count, output, 32: count of completed packets.

Function
REQ-019 SHALL implement a two-state FSM: IDLE and XFER.
REQ-020 A queue k SHALL be eligible when q_valid[k] and space_ok[k] are both 1.
REQ-021 In IDLE, with next_pkg_en=1 and at least one queue eligible, SHALL pick the first eligible queue searching upward from rr_ptr with modulo-NUM_QUEUES wrap.
REQ-022 On that pick, SHALL register grant/queue_id and enter XFER on the next edge.
REQ-023 IDLE SHALL drive q_ready=0 and dout_valid=0.
REQ-024 In XFER, for granted queue g: dout=q_data[g], dout_valid=q_valid[g], dout_last=q_last[g], q_ready[g]=dout_ready; all other q_ready bits SHALL be 0 (combinational pass-through, zero latency).
REQ-025 A word SHALL transfer on an edge where dout_valid and dout_ready are both 1.
REQ-026 A transfer with dout_last=1 SHALL:
  - return the FSM to IDLE;
  - set rr_ptr = (g+1) mod NUM_QUEUES (wrap 4->0);
  - increment pkt_count (wrap at 2^32-1 -> 0).
REQ-027 Each packet SHALL incur exactly one IDLE bubble cycle between its last word and the next grant's first word.
REQ-028 next_pkg_en deasserting during XFER SHALL NOT abort the packet; it only blocks new grants in IDLE.
REQ-029 A space_ok deassertion during XFER SHALL be ignored.
REQ-030 q_valid[g]=0 mid-packet SHALL stall the packet with no timeout.
REQ-031 A single-word packet (q_last on the first word) SHALL occupy one XFER cycle.
REQ-032 busy SHALL be 1 exactly in XFER.
REQ-033 queue_id SHALL hold its last grant value while in IDLE.

Reset
REQ-034 On memreset=1 at a rising edge, SHALL set: state=IDLE, rr_ptr=0, queue_id=0, grant=0, pkt_count=0.
REQ-035 memreset=1 SHALL force q_ready=0, dout_valid=0, dout_last=0, busy=0 while asserted.
REQ-036 memreset mid-packet SHALL abandon the packet with no partial-packet recovery.
REQ-037 memreset SHALL take priority over every other event.

Structure
REQ-038 NUM_QUEUES, DATA_WIDTH, QID_WIDTH defaults and the IDLE/XFER state encodings SHALL live in the shared output-queue package.
REQ-039 The rotating priority pick SHALL be one sub-module, rr_pick: inputs eligible vector and rr_ptr; outputs found and binary index.
REQ-040 A competent implementation SHALL be 120-400 lines of RTL.

Verification
REQ-041 Reset, then q_valid=5'b00101, space_ok=all 1, 3-word packets -> grants in order 0, 2, 0, 2; pkt_count=4; one bubble cycle between packets.
REQ-042 rr_ptr=4 with queues 4 and 1 eligible -> grant queue 4, then queue 1 (wrap); queue_id=4 then 1.
REQ-043 Queue 3 valid with space_ok[3]=0, queue 1 valid -> queue 1 granted; queue 3 never granted until space_ok[3]=1.
REQ-044 dout_ready toggling 1,0,1,0 during a 4-word packet -> words are output unchanged and in order, q_ready[g] mirrors dout_ready, and no other queue receives q_ready.
REQ-045 next_pkg_en dropped in the 2nd word of 5 -> all 5 words complete; no new grant until next_pkg_en=1.
REQ-046 memreset asserted in the 3rd word -> next cycle busy=0, q_ready=0, pkt_count=0, and the next grant starts from queue 0.
